// File: rtl/cpm_sel_iter.sv
// cpm_sel_iter: walks every set bit of a captured multi-hot select mask and
// streams out one index per beat (valid/ready), in MSB-first or LSB-first order.
// Each beat carries the index, its 0-based ordinal and a last flag.
// The mask popcount is held from capture until the next capture.
module cpm_sel_iter #(
    parameter int DW        = 8,
    parameter int AW        = $clog2(DW),
    parameter int CW        = $clog2(DW + 1),
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          CLR,
    input  logic          IN_VLD,
    output logic          IN_RDY,
    input  logic [DW-1:0] IN_SEL,
    output logic          OUT_VLD,
    input  logic          OUT_RDY,
    output logic [AW-1:0] OUT_IDX,
    output logic          OUT_LAST,
    output logic [AW-1:0] OUT_CNT,
    output logic [CW-1:0] OUT_NUM,
    output logic          DONE
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [DW-1:0] ONE_HOT0 = DW'(1);

    // Number of set bits in a mask; needs CW bits so an all-ones mask fits.
    function automatic logic [CW-1:0] popcount(input logic [DW-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < DW; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Priority encoder: highest set bit when MSB_FIRST, lowest otherwise; 0 for an empty mask.
    function automatic logic [AW-1:0] prio_idx(input logic [DW-1:0] v);
        logic [AW-1:0] idx;
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < DW; i++) begin
                if (v[i]) idx = AW'(i);
            end
        end else begin
            for (int i = DW - 1; i >= 0; i--) begin
                if (v[i]) idx = AW'(i);
            end
        end
        return idx;
    endfunction

    state_e        state_q, state_d;
    logic [DW-1:0] mask_q,  mask_d;
    logic [AW-1:0] cnt_q,   cnt_d;
    logic [CW-1:0] num_q,   num_d;
    logic          done_q,  done_d;

    logic [AW-1:0] sel_idx_s;
    logic [DW-1:0] rest_mask_s;
    logic          last_s;

    // Current beat decode, purely from registered state (no path from IN_* or OUT_RDY).
    always_comb begin
        sel_idx_s   = prio_idx(mask_q);
        rest_mask_s = mask_q & ~(ONE_HOT0 << sel_idx_s);
        last_s      = (state_q == ST_RUN) && (rest_mask_s == '0);
    end

    // Next-state logic: capture in IDLE, consume one bit per accepted beat in RUN, CLR overrides all.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        done_d  = 1'b0;
        if (CLR) begin
            // Abort drops the mask but keeps the popcount of the last capture visible.
            state_d = ST_IDLE;
            mask_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (IN_VLD) begin
                        mask_d = IN_SEL;
                        num_d  = popcount(IN_SEL);
                        cnt_d  = '0;
                        if (IN_SEL == '0) begin
                            // Empty mask: nothing to emit, report completion straight away.
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (OUT_RDY) begin
                        mask_d = rest_mask_s;
                        if (last_s) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + AW'(1);
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    mask_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            done_q  <= done_d;
        end
    end

    assign IN_RDY   = (state_q == ST_IDLE);
    assign OUT_VLD  = (state_q == ST_RUN);
    assign OUT_IDX  = sel_idx_s;
    assign OUT_LAST = last_s;
    assign OUT_CNT  = cnt_q;
    assign OUT_NUM  = num_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_cpm_sel_iter.sv
// Bench for cpm_sel_iter: an MSB-first and an LSB-first instance share stimulus;
// a list-based reference model predicts every output each cycle.
module tb_cpm_sel_iter;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_vld;
    logic [7:0] in_sel;
    logic       out_rdy;

    logic       in_rdy_m, out_vld_m, out_last_m, done_m;
    logic [2:0] out_idx_m, out_cnt_m;
    logic [3:0] out_num_m;
    logic       in_rdy_l, out_vld_l, out_last_l, done_l;
    logic [2:0] out_idx_l, out_cnt_l;
    logic [3:0] out_num_l;

    int checks = 0;
    int errors = 0;

    cpm_sel_iter #(.DW(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .CLR(clr), .IN_VLD(in_vld), .IN_RDY(in_rdy_m),
        .IN_SEL(in_sel), .OUT_VLD(out_vld_m), .OUT_RDY(out_rdy), .OUT_IDX(out_idx_m),
        .OUT_LAST(out_last_m), .OUT_CNT(out_cnt_m), .OUT_NUM(out_num_m), .DONE(done_m)
    );

    cpm_sel_iter #(.DW(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .CLR(clr), .IN_VLD(in_vld), .IN_RDY(in_rdy_l),
        .IN_SEL(in_sel), .OUT_VLD(out_vld_l), .OUT_RDY(out_rdy), .OUT_IDX(out_idx_l),
        .OUT_LAST(out_last_l), .OUT_CNT(out_cnt_l), .OUT_NUM(out_num_l), .DONE(done_l)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: at capture the mask becomes an ordered index list per direction;
    // a position pointer walks the list one entry per accepted beat.
    bit m_busy;
    int m_pos, m_len, m_num;
    bit m_done;
    int ord_m[8];
    int ord_l[8];

    // Model update on the same edges as the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_pos  <= 0;
            m_len  <= 0;
            m_num  <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (clr) begin
                m_busy <= 1'b0;
                m_pos  <= 0;
            end else if (!m_busy) begin
                if (in_vld) begin
                    int k;
                    int j;
                    k = 0;
                    for (int i = 7; i >= 0; i--) begin
                        if (in_sel[i]) begin
                            ord_m[k] <= i;
                            k++;
                        end
                    end
                    j = 0;
                    for (int i = 0; i < 8; i++) begin
                        if (in_sel[i]) begin
                            ord_l[j] <= i;
                            j++;
                        end
                    end
                    m_len <= k;
                    m_num <= k;
                    m_pos <= 0;
                    if (k == 0) m_done <= 1'b1;
                    else        m_busy <= 1'b1;
                end
            end else if (out_rdy) begin
                if (m_pos == m_len - 1) begin
                    m_busy <= 1'b0;
                    m_pos  <= 0;
                    m_done <= 1'b1;
                end else begin
                    m_pos <= m_pos + 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check_val("in_rdy_m",  in_rdy_m,  !m_busy);
            check_val("in_rdy_l",  in_rdy_l,  !m_busy);
            check_val("out_vld_m", out_vld_m, m_busy);
            check_val("out_vld_l", out_vld_l, m_busy);
            check_val("done_m",    done_m,    m_done);
            check_val("done_l",    done_l,    m_done);
            check_val("num_m",     out_num_m, m_num);
            check_val("num_l",     out_num_l, m_num);
            check_val("cnt_m",     out_cnt_m, m_pos);
            check_val("cnt_l",     out_cnt_l, m_pos);
            check_val("last_m",    out_last_m, m_busy && (m_pos == m_len - 1));
            check_val("last_l",    out_last_l, m_busy && (m_pos == m_len - 1));
            if (m_busy) begin
                check_val("idx_m", out_idx_m, ord_m[m_pos]);
                check_val("idx_l", out_idx_l, ord_l[m_pos]);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_vld_m"},  out_vld_m,  0);
        check_val({tag, "_vld_l"},  out_vld_l,  0);
        check_val({tag, "_idx_m"},  out_idx_m,  0);
        check_val({tag, "_last_m"}, out_last_m, 0);
        check_val({tag, "_last_l"}, out_last_l, 0);
        check_val({tag, "_cnt_m"},  out_cnt_m,  0);
        check_val({tag, "_num_m"},  out_num_m,  0);
        check_val({tag, "_done_m"}, done_m,     0);
        check_val({tag, "_rdy_m"},  in_rdy_m,   1);
        check_val({tag, "_rdy_l"},  in_rdy_l,   1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!in_rdy_m && n < budget) begin
            step();
            n++;
        end
        check_val("idle_reached", in_rdy_m, 1);
    endtask

    task automatic send(input logic [7:0] m);
        wait_idle(50);
        in_vld = 1'b1;
        in_sel = m;
        step();
        in_vld = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        clr     = 1'b0;
        in_vld  = 1'b0;
        in_sel  = 8'h00;
        out_rdy = 1'b1;
        step();
        step();
        check_reset_values("reset");
        rst_n = 1'b1;
        step();

        // MSB order 7,5,2,1 and LSB order 1,2,5,7 at full rate.
        send(8'hA6);
        repeat (6) step();

        // Backpressure on beat 1 for three cycles.
        send(8'hA6);
        step();
        out_rdy = 1'b0;
        repeat (3) step();
        out_rdy = 1'b1;
        wait_idle(20);

        // Empty mask.
        send(8'h00);
        repeat (2) step();

        // Full mask, then a single-bit mask back to back.
        send(8'hFF);
        send(8'h01);
        wait_idle(20);
        step();

        // CLR at beat 2, then CLR together with IN_VLD in IDLE.
        send(8'hA6);
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        in_vld = 1'b1;
        in_sel = 8'h3C;
        clr    = 1'b1;
        step();
        clr    = 1'b0;
        in_vld = 1'b0;
        step();

        // Asynchronous reset in the middle of a run.
        send(8'hFF);
        step();
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        step();
        rst_n = 1'b1;
        step();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 7))
                0:       in_sel = 8'h00;
                1:       in_sel = 8'hFF;
                default: in_sel = 8'($urandom);
            endcase
            in_vld  = ($urandom_range(0, 2) != 0);
            out_rdy = ($urandom_range(0, 3) != 0);
            clr     = ($urandom_range(0, 39) == 0);
            step();
        end
        clr     = 1'b0;
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        wait_idle(20);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
